seven_segment_scan_decoder: RTL and testbench



---
 rtl/seven_segment_scan_decoder.sv | 127 ++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// Watches a multiplexed seven-segment bus and recovers the BCD digit held in each position.
// Capture happens STABLE_CYCLES edges after a pair is first sampled; illegal patterns pulse pattern_err.
module seven_segment_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  pattern_err,
  output logic                  frame_done
);

  typedef enum logic {WAIT, HELD} state_t;

  localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  state_t              state_q, state_d;
  logic [6:0]          s_seg_q, s_seg_d;
  logic [DIGITS-1:0]   s_an_q, s_an_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                err_q, err_d;
  logic                frame_q, frame_d;

  logic                changed;
  logic                capture;
  logic [4:0]          dec;
  logic [DIGITS-1:0]   seen_next;

  // Bit 4 flags a legal pattern; bits 3:0 carry the digit.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0111111: decode = 5'h10;
      7'b0000110: decode = 5'h11;
      7'b1011011: decode = 5'h12;
      7'b1001111: decode = 5'h13;
      7'b1100110: decode = 5'h14;
      7'b1101101: decode = 5'h15;
      7'b1111101: decode = 5'h16;
      7'b0000111: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1100111: decode = 5'h19;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    s_seg_d   = seg_in;
    s_an_d    = an_in;
    cnt_d     = cnt_q;
    state_d   = state_q;
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    err_d     = 1'b0;
    frame_d   = 1'b0;
    seen_next = seen_q;

    changed = (seg_in != s_seg_q) || (an_in != s_an_q);
    capture = (state_q == WAIT) && (cnt_q == CNT_MAX) && $onehot(s_an_q);
    dec     = decode(s_seg_q);

    if (changed) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    // A change on the capture edge still lets the capture finish, then restarts acquisition.
    if (capture) state_d = HELD;
    if (changed) state_d = WAIT;

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (s_an_q[i]) begin
          valid_d[i] = dec[4];
          if (dec[4]) digits_d[4*i +: 4] = dec[3:0];
        end
      end
      err_d     = !dec[4];
      seen_next = seen_q | s_an_q;
      if (&seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT;
      s_seg_q  <= '0;
      s_an_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_seg_q  <= s_seg_d;
      s_an_q   <= s_an_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign pattern_err = err_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder at DIGITS=4, STABLE_CYCLES=3.
module tb_seven_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic        pattern_err;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;
  localparam logic [6:0] SEG2 = 7'b1011011;
  localparam logic [6:0] SEG3 = 7'b1001111;
  localparam logic [6:0] SEG4 = 7'b1100110;
  localparam logic [6:0] SEG5 = 7'b1101101;
  localparam logic [6:0] SEG7 = 7'b0000111;
  localparam logic [6:0] SEG8 = 7'b1111111;
  localparam logic [6:0] SEG9 = 7'b1100111;

  seven_segment_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [6:0] scan_seg [4];
  int errs;
  int frames;

  initial begin
    scan_seg[0] = SEG1;
    scan_seg[1] = SEG9;
    scan_seg[2] = SEG8;
    scan_seg[3] = SEG0;

    // Reset then idle
    rst = 1'b1; seg_in = '0; an_in = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", {digits_out, digit_valid, pattern_err, frame_done}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", {digits_out, digit_valid, pattern_err, frame_done}, 32'h0);
    end

    // Single position: digit 2 at position 0, update on the 4th edge after driving
    an_in = 4'b0001; seg_in = SEG2;
    tick(); tick(); tick();
    check("single_before", {digits_out, digit_valid}, 32'h0);
    tick();
    check("single_digit", digits_out[3:0], 4'd2);
    check("single_valid", digit_valid, 4'b0001);
    check("single_err", pattern_err, 1'b0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      errs += int'(pattern_err);
      check("single_hold", {digits_out, digit_valid}, {16'h0002, 4'b0001});
    end
    check("single_no_err", errs, 0);

    // Glitch rejection at position 1
    an_in = 4'b0010; seg_in = SEG4;
    tick(); tick();
    seg_in = SEG5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("glitch_no_capture", digit_valid[1], 1'b0);
    end
    tick();
    check("glitch_digit", digits_out[7:4], 4'd5);
    check("glitch_valid", digit_valid, 4'b0011);

    // Illegal pattern after position 0 holds 7
    an_in = 4'b0001; seg_in = SEG7;
    for (int i = 0; i < 5; i++) tick();
    check("setup_seven", digits_out[3:0], 4'd7);
    seg_in = 7'b1000000;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      errs += int'(pattern_err);
    end
    check("illegal_err_pulses", errs, 1);
    check("illegal_valid0", digit_valid[0], 1'b0);
    check("illegal_digit_kept", digits_out[3:0], 4'd7);
    check("illegal_other_pos", digits_out[7:4], 4'd5);

    // Full scan, twice; positions 0 and 1 are already in the seen mask
    an_in = '0; seg_in = '0;
    tick();
    for (int s = 0; s < 2; s++) begin
      frames = 0;
      errs   = 0;
      for (int p = 0; p < 4; p++) begin
        an_in = 4'b0001 << p; seg_in = scan_seg[p];
        for (int t = 1; t <= 5; t++) begin
          tick();
          frames += int'(frame_done);
          errs   += int'(pattern_err);
          if (p == 3 && t == 4) check("scan_frame_at_pos3", frame_done, 1'b1);
        end
        an_in = '0; seg_in = '0;
        tick();
        frames += int'(frame_done);
      end
      check("scan_frame_count", frames, 1);
      check("scan_no_err", errs, 0);
      check("scan_digits", digits_out, 16'h0891);
      check("scan_valid", digit_valid, 4'hF);
    end

    // Multi-hot strobe: nothing captured
    an_in = 4'b0011; seg_in = SEG3;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      errs += int'(pattern_err) + int'(frame_done);
    end
    check("multihot_no_pulse", errs, 0);
    check("multihot_state", {digits_out, digit_valid}, {16'h0891, 4'hF});

    // Reset mid-count at position 2, then re-acquisition from scratch
    an_in = 4'b0100; seg_in = SEG3;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_clear", {digits_out, digit_valid, pattern_err, frame_done}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset_reacq_wait", {digits_out, digit_valid}, 32'h0);
    end
    tick();
    check("midreset_reacq_digits", digits_out, 16'h0300);
    check("midreset_reacq_valid", digit_valid, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
